id_exe_reg: RTL and testbench

Pipeline register between the ID stage (decoder/controller plus register-file read) and the EXE stage of the 5-stage ARM core.
- Captures the decoded control bundle, operands, immediates and register addresses each cycle.
- Supports hazard freeze (hold) and branch flush (bubble insert).
- Carries a valid bit so downstream stages and the forwarding unit ignore bubbles.

---
 rtl/id_exe_reg_pkg.sv | 35 +++
 rtl/id_exe_reg_field.sv | 22 ++
 rtl/id_exe_reg.sv | 127 ++++++++++++
 tb/tb_id_exe_reg.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/id_exe_reg_pkg.sv
// Shared definitions for the ID/EXE pipeline register: ALU command encodings,
// the control bundle carried into EXE, and the default datapath widths.
package id_exe_reg_pkg;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_REG_ADDR_W = 4;
  localparam int STAT_W         = 16;

  typedef enum logic [3:0] {
    EXE_MOV = 4'b0001,
    EXE_MVN = 4'b1001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000
  } exe_cmd_e;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  // Saturating increment for the hazard statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/id_exe_reg_field.sv
// Generic pipeline field register: reset and flush clear, freeze holds,
// otherwise load on every rising edge.
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         freeze,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= '0;
    end else if (!freeze) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze (hold) and flush (bubble) control.
// Optional hazard statistics counters are built when HAZARD_STAT_EN is defined.
module id_exe_reg
  import id_exe_reg_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic [3:0]            exe_cmd_in,
  input  logic [WORD_W-1:0]     pc_in,
  input  logic [WORD_W-1:0]     val_rn_in,
  input  logic [WORD_W-1:0]     val_rm_in,
  input  logic                  imm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  input  logic                  c_in,
  output logic                  valid,
  output logic                  wb_en,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic                  b,
  output logic                  s,
  output logic [3:0]            exe_cmd,
  output logic [WORD_W-1:0]     pc,
  output logic [WORD_W-1:0]     val_rn,
  output logic [WORD_W-1:0]     val_rm,
  output logic                  imm,
  output logic [11:0]           shift_operand,
  output logic [23:0]           signed_imm_24,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2,
  output logic                  c
`ifdef HAZARD_STAT_EN
  ,
  input  logic                  stat_clr,
  output logic [STAT_W-1:0]     freeze_cnt,
  output logic [STAT_W-1:0]     flush_cnt
`endif
);

  localparam int DATA_W = 3*WORD_W + 1 + 12 + 24 + 3*REG_ADDR_W + 1;

  ctrl_t             ctrl_d;
  ctrl_t             ctrl_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  // An invalid slot must never enable write-back, memory, branch or flags.
  always_comb begin
    ctrl_d          = '0;
    ctrl_d.wb_en    = wb_en_in    & valid_in;
    ctrl_d.mem_r_en = mem_r_en_in & valid_in;
    ctrl_d.mem_w_en = mem_w_en_in & valid_in;
    ctrl_d.b        = b_in        & valid_in;
    ctrl_d.s        = s_in        & valid_in;
    ctrl_d.exe_cmd  = exe_cmd_in;
  end

  assign data_d = {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                   signed_imm_24_in, dest_in, src1_in, src2_in, c_in};

  pipe_field_reg #(.W(1)) u_valid (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .freeze(freeze),
    .d     (valid_in),
    .q     (valid)
  );

  pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .freeze(freeze),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  pipe_field_reg #(.W(DATA_W)) u_data (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .freeze(freeze),
    .d     (data_d),
    .q     (data_q)
  );

  assign wb_en    = ctrl_q.wb_en;
  assign mem_r_en = ctrl_q.mem_r_en;
  assign mem_w_en = ctrl_q.mem_w_en;
  assign b        = ctrl_q.b;
  assign s        = ctrl_q.s;
  assign exe_cmd  = ctrl_q.exe_cmd;

  assign {pc, val_rn, val_rm, imm, shift_operand,
          signed_imm_24, dest, src1, src2, c} = data_q;

`ifdef HAZARD_STAT_EN
  // A freeze overridden by flush is not an accepted stall, so it is not counted.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      freeze_cnt <= '0;
      flush_cnt  <= '0;
    end else if (flush) begin
      flush_cnt <= sat_inc(flush_cnt);
    end else if (freeze) begin
      freeze_cnt <= sat_inc(freeze_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed, table-driven bench for id_exe_reg; the counter checks are built
// only when HAZARD_STAT_EN is defined.
module tb_id_exe_reg;

  typedef struct packed {
    logic        valid;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        b;
    logic        s;
    logic [3:0]  exe_cmd;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        c;
  } fld_t;

  typedef struct {
    logic rst;
    logic flush;
    logic freeze;
    fld_t in;
    fld_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, flush, freeze;
  fld_t drv, got;

  logic valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, c_in;
  logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;

  logic valid, wb_en, mem_r_en, mem_w_en, b, s, imm, c;
  logic [3:0]  exe_cmd, dest, src1, src2;
  logic [31:0] pc, val_rn, val_rm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;

`ifdef HAZARD_STAT_EN
  logic        stat_clr;
  logic [15:0] freeze_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign {valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
          pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
          signed_imm_24_in, dest_in, src1_in, src2_in, c_in} = drv;
  assign got = {valid, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd,
                pc, val_rn, val_rm, imm, shift_operand,
                signed_imm_24, dest, src1, src2, c};

  id_exe_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .valid_in(valid_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in),
    .exe_cmd_in(exe_cmd_in), .pc_in(pc_in), .val_rn_in(val_rn_in),
    .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .c_in(c_in),
    .valid(valid), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .b(b), .s(s), .exe_cmd(exe_cmd), .pc(pc), .val_rn(val_rn),
    .val_rm(val_rm), .imm(imm), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .dest(dest), .src1(src1), .src2(src2),
    .c(c)
`ifdef HAZARD_STAT_EN
    , .stat_clr(stat_clr), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
`endif
  );

  function automatic fld_t mk(input logic v, wb, mr, mw, br, st,
                              input logic [3:0] cmd, input logic [31:0] pcv,
                              input logic [31:0] rn, input logic [31:0] rm,
                              input logic im, input logic [11:0] sh,
                              input logic [23:0] si, input logic [3:0] d,
                              input logic [3:0] s1, input logic [3:0] s2,
                              input logic cc);
    fld_t f;
    f.valid = v; f.wb_en = wb; f.mem_r_en = mr; f.mem_w_en = mw;
    f.b = br; f.s = st; f.exe_cmd = cmd; f.pc = pcv; f.val_rn = rn;
    f.val_rm = rm; f.imm = im; f.shift_operand = sh; f.signed_imm_24 = si;
    f.dest = d; f.src1 = s1; f.src2 = s2; f.c = cc;
    return f;
  endfunction

  function automatic vec_t mv(input logic r, fl, fr, input fld_t i, input fld_t e);
    vec_t v;
    v.rst = r; v.flush = fl; v.freeze = fr; v.in = i; v.exp = e;
    return v;
  endfunction

  task automatic check_fld(input string name, input fld_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

`ifdef HAZARD_STAT_EN
  task automatic check_cnt(input string name, input logic [15:0] fz, input logic [15:0] fl);
    checks++;
    if (freeze_cnt !== fz || flush_cnt !== fl) begin
      failures++;
      $display("FAIL %s got freeze_cnt=%h flush_cnt=%h exp freeze_cnt=%h flush_cnt=%h",
               name, freeze_cnt, flush_cnt, fz, fl);
    end
  endtask

  task automatic step_stat(input logic fr, input logic fl, input logic clr);
    @(negedge clk);
    freeze = fr; flush = fl; stat_clr = clr;
    @(posedge clk);
    #1;
  endtask
`endif

  vec_t tbl[15];
  fld_t ones, zero, op_add, op_sub, op_str, bub_in, bub_exp;

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0; drv = '0;
`ifdef HAZARD_STAT_EN
    stat_clr = 1'b0;
`endif
    ones    = '1;
    zero    = '0;
    op_add  = mk(1,1,0,0,0,0, 4'b0010, 32'h0000_0104, 32'h0000_0005, 32'h0000_0007,
                 0, 12'h003, 24'h000000, 4'd3, 4'd1, 4'd2, 1);
    op_sub  = mk(1,1,0,0,0,1, 4'b0100, 32'h0000_0108, 32'h0000_0009, 32'h0000_0002,
                 1, 12'h0A5, 24'h000010, 4'd5, 4'd6, 4'd7, 0);
    op_str  = mk(1,0,0,1,0,0, 4'b0010, 32'h0000_010C, 32'h1000_0000, 32'hDEAD_BEEF,
                 1, 12'h008, 24'h000000, 4'd0, 4'd8, 4'd9, 1);
    bub_in  = mk(0,1,1,1,1,1, 4'b0011, 32'h0000_0110, 32'hCAFE_0001, 32'h1234_5678,
                 1, 12'hABC, 24'hFFFFFE, 4'd12, 4'd13, 4'd14, 1);
    bub_exp = mk(0,0,0,0,0,0, 4'b0011, 32'h0000_0110, 32'hCAFE_0001, 32'h1234_5678,
                 1, 12'hABC, 24'hFFFFFE, 4'd12, 4'd13, 4'd14, 1);

    tbl[0]  = mv(1,0,0, ones,   zero);    // reset with all-ones inputs
    tbl[1]  = mv(1,1,1, ones,   zero);    // reset beats flush and freeze
    tbl[2]  = mv(0,0,0, op_add, op_add);  // normal load
    tbl[3]  = mv(0,0,1, op_sub, op_add);  // freeze window x3
    tbl[4]  = mv(0,0,1, op_sub, op_add);
    tbl[5]  = mv(0,0,1, op_sub, op_add);
    tbl[6]  = mv(0,0,0, op_sub, op_sub);  // release
    tbl[7]  = mv(0,1,1, op_str, zero);    // flush beats freeze
    tbl[8]  = mv(0,0,0, op_str, op_str);
    tbl[9]  = mv(0,1,0, ones,   zero);    // consecutive flushes
    tbl[10] = mv(0,1,0, ones,   zero);
    tbl[11] = mv(0,0,0, bub_in, bub_exp); // invalid slot: enables cleared
    tbl[12] = mv(0,0,0, ones,   ones);
    tbl[13] = mv(1,0,1, zero,   zero);    // reset beats freeze
    tbl[14] = mv(0,0,1, ones,   zero);    // freeze holds reset value

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; flush = tbl[i].flush; freeze = tbl[i].freeze;
      drv = tbl[i].in;
      @(posedge clk);
      #1;
      check_fld($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Load, then change inputs mid-cycle: outputs must not follow until the edge.
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; freeze = 1'b0; drv = op_add;
    @(posedge clk);
    #1;
    drv = op_str;
    #2;
    check_fld("no_comb_path", op_add);
    @(posedge clk);
    #1;
    check_fld("load_after_change", op_str);

`ifdef HAZARD_STAT_EN
    step_stat(0, 0, 1);
    check_cnt("stat_clear_init", 16'd0, 16'd0);
    for (int i = 0; i < 5; i++) step_stat(1, 0, 0);
    for (int i = 0; i < 2; i++) step_stat(0, 1, 0);
    step_stat(1, 1, 0);
    check_cnt("stat_counts", 16'd5, 16'd3);
    step_stat(1, 1, 1);
    check_cnt("stat_clr_priority", 16'd0, 16'd0);
    @(negedge clk);
    freeze = 1'b1; flush = 1'b0; stat_clr = 1'b0;
    repeat (65537) @(posedge clk);
    #1;
    check_cnt("freeze_saturate", 16'hFFFF, 16'd0);
    step_stat(1, 0, 0);
    check_cnt("freeze_sat_hold", 16'hFFFF, 16'd0);
    step_stat(0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
